// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory bus controller.
//   state_t          : controller FSM states (IDLE, REQ, DONE)
//   F3_*             : load/store width codes carried on funct3
//   is_misaligned()  : width/address alignment test used when
//                      DMEM_MISALIGN_TRAP_EN is defined
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return (lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// dmem_timeout_cnt -- counts bus-request cycles and flags the last one.
//   clk, reset : clock, synchronous active-high reset
//   clear      : return count to zero
//   enable     : one bus-request cycle is in progress
//   expired    : high during the TIMEOUT-th enabled cycle
module dmem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    // count holds the number of enabled cycles already completed
    assign expired = enable && (count == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 8'd1;
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl -- single-outstanding-access bridge from the datapath
// load/store stage to the data RAM bus.
//   clk, reset              : clock, synchronous active-high reset
//   mem_read, mem_write     : access request (both high = write)
//   addr, funct3            : byte address and width code
//   wdata, byte_en          : lane-shifted store data and lane enables
//   stall                   : hold the pipeline while the access is open
//   rdata, rdata_valid      : returned word and its one-cycle strobe
//   bus_req/we/addr/wdata/be: request to data RAM
//   bus_ack, bus_rdata      : response from data RAM
//   bus_err                 : one-cycle pulse on timeout or misalignment
//   misalign                : present only with DMEM_MISALIGN_TRAP_EN
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned H/HU/W trap).
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        bus_err
);

    state_t      state, state_next;
    logic [29:0] cap_word;
    logic        cap_we;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        err_q, err_next;
    logic        capture, rd_load, rd_clear;
    logic        cnt_clear, cnt_en, expired;
    logic        mis_now, misalign_hit;
    logic        req_any, null_write;

    assign req_any    = mem_read | mem_write;
    assign null_write = mem_write && (byte_en == 4'b0000);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis_now  = is_misaligned(funct3, addr[1:0]);
    assign misalign = misalign_hit;
`else
    // width/low address bits only matter to the trap; access is word-aligned
    logic unused_bits;
    assign mis_now     = 1'b0;
    assign unused_bits = ^{funct3, addr[1:0]};
`endif

    dmem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );

    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        capture      = 1'b0;
        rd_load      = 1'b0;
        rd_clear     = 1'b0;
        err_next     = 1'b0;
        cnt_clear    = 1'b1;
        cnt_en       = 1'b0;
        misalign_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_any && !null_write) begin
                    if (mis_now) begin
                        misalign_hit = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        capture    = 1'b1;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall     = 1'b1;
                cnt_clear = 1'b0;
                cnt_en    = 1'b1;
                if (bus_ack) begin
                    rd_load    = !cap_we;
                    state_next = ST_DONE;
                end else if (expired) begin
                    rd_clear   = 1'b1;
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cap_word  <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
            cap_be    <= '0;
            rdata     <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= err_next;
            if (capture) begin
                cap_word  <= addr[31:2];
                cap_we    <= mem_write;
                cap_wdata <= wdata;
                cap_be    <= mem_write ? byte_en : 4'b1111;
            end
            if (rd_load)
                rdata <= bus_rdata;
            else if (rd_clear)
                rdata <= '0;
        end
    end

    assign bus_req     = (state == ST_REQ);
    assign bus_we      = cap_we;
    assign bus_addr    = {cap_word, 2'b00};
    assign bus_wdata   = cap_wdata;
    assign bus_be      = cap_be;
    assign rdata_valid = (state == ST_DONE) && !cap_we;
    assign bus_err     = err_q | misalign_hit;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb_dmem_bus_ctrl -- directed self-checking bench for dmem_bus_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are compared
// 2 time units after the rising edge.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN.
module tb_dmem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n;

    always #5 clk = ~clk;

    dmem_bus_ctrl #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .addr        (addr),
        .funct3      (funct3),
        .wdata       (wdata),
        .byte_en     (byte_en),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
`ifdef DMEM_MISALIGN_TRAP_EN
        .misalign    (misalign),
`endif
        .bus_err     (bus_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        funct3    = 3'b000;
        wdata     = '0;
        byte_en   = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        tick(); tick();
        #1;
        check_eq("rst_stall",  stall,       0);
        check_eq("rst_req",    bus_req,     0);
        check_eq("rst_we",     bus_we,      0);
        check_eq("rst_addr",   bus_addr,    0);
        check_eq("rst_wdata",  bus_wdata,   0);
        check_eq("rst_be",     bus_be,      0);
        check_eq("rst_rdata",  rdata,       0);
        check_eq("rst_rvalid", rdata_valid, 0);
        check_eq("rst_err",    bus_err,     0);
        tick();
        reset = 1'b0;

        // word read, ack on first REQ cycle
        tick();
        mem_read = 1'b1; addr = 32'h104; funct3 = 3'b010; byte_en = 4'b0001;
        #1;
        check_eq("rd_stall_c0", stall,   1);
        check_eq("rd_req_c0",   bus_req, 0);
        tick();
        quiet(); bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        #1;
        check_eq("rd_req_c1",   bus_req,  1);
        check_eq("rd_addr",     bus_addr, 32'h104);
        check_eq("rd_be",       bus_be,   4'b1111);
        check_eq("rd_we",       bus_we,   0);
        check_eq("rd_stall_c1", stall,    1);
        tick();
        quiet(); mem_read = 1'b1; addr = 32'h500;  // ignored while in DONE
        #1;
        check_eq("rd_valid",    rdata_valid, 1);
        check_eq("rd_data",     rdata,       32'hDEADBEEF);
        check_eq("rd_stall_c2", stall,       0);
        check_eq("rd_req_c2",   bus_req,     0);
        tick();
        quiet();
        #1;
        check_eq("rd_done_ign", bus_req,     0);
        check_eq("rd_valid_1",  rdata_valid, 0);
        check_eq("rd_hold",     rdata,       32'hDEADBEEF);

        // store byte, ack on third REQ cycle
        tick();
        mem_write = 1'b1; addr = 32'h203; funct3 = 3'b000;
        wdata = 32'hAB000000; byte_en = 4'b1000;
        #1;
        check_eq("sb_stall_c0", stall, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            quiet(); bus_ack = (i == 2);
            #1;
            check_eq("sb_req",   bus_req,   1);
            check_eq("sb_we",    bus_we,    1);
            check_eq("sb_addr",  bus_addr,  32'h200);
            check_eq("sb_be",    bus_be,    4'b1000);
            check_eq("sb_wdata", bus_wdata, 32'hAB000000);
            check_eq("sb_stall", stall,     1);
        end
        tick();
        quiet();
        #1;
        check_eq("sb_stall_dn", stall,       0);
        check_eq("sb_rvalid",   rdata_valid, 0);
        check_eq("sb_req_dn",   bus_req,     0);
        check_eq("sb_rhold",    rdata,       32'hDEADBEEF);

        // read with no ack: timeout after 16 REQ cycles
        tick();
        mem_read = 1'b1; addr = 32'h40; funct3 = 3'b010;
        tick();
        quiet();
        #1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus_req) break;
            if (bus_err) check_eq("to_err_early", bus_err, 0);
            n++;
            tick();
            #1;
        end
        check_eq("to_req_cycles", n,           16);
        check_eq("to_err",        bus_err,     1);
        check_eq("to_rvalid",     rdata_valid, 1);
        check_eq("to_rdata",      rdata,       0);
        tick();
        bus_ack = 1'b1;  // ack outside REQ has no effect
        #1;
        check_eq("to_err_pulse", bus_err, 0);
        check_eq("to_req_idle",  bus_req, 0);
        tick();
        quiet();
        #1;
        check_eq("stray_ack_req",   bus_req, 0);
        check_eq("stray_ack_stall", stall,   0);

        // reset on second REQ cycle aborts silently
        tick();
        bus_rdata = 32'h55AA55AA;
        mem_read = 1'b1; addr = 32'h80; funct3 = 3'b010;
        tick();
        mem_read = 1'b0;
        #1;
        check_eq("rst_req_c1", bus_req, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("rstq_req",    bus_req,     0);
        check_eq("rstq_rvalid", rdata_valid, 0);
        check_eq("rstq_stall",  stall,       0);
        tick();
        #1;
        check_eq("rstq_rvalid2", rdata_valid, 0);
        check_eq("rstq_rdata",   rdata,       0);

        // read+write together is a write
        tick();
        mem_read = 1'b1; mem_write = 1'b1; addr = 32'h302; funct3 = 3'b001;
        wdata = 32'h00001234; byte_en = 4'b0011; bus_rdata = 32'hFFFFFFFF;
        #1;
        check_eq("rw_stall", stall, 1);
        tick();
        quiet(); bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        #1;
        check_eq("rw_we",   bus_we,   1);
        check_eq("rw_be",   bus_be,   4'b0011);
        check_eq("rw_addr", bus_addr, 32'h300);
        tick();
        quiet();
        #1;
        check_eq("rw_rvalid", rdata_valid, 0);
        check_eq("rw_rdata",  rdata,       0);

        // write with no lanes completes without a bus cycle
        tick();
        mem_write = 1'b1; addr = 32'h400; byte_en = 4'b0000;
        #1;
        check_eq("nw_stall", stall, 0);
        tick();
        quiet();
        #1;
        check_eq("nw_req", bus_req, 0);

        // misaligned word load
        tick();
        mem_read = 1'b1; addr = 32'h102; funct3 = 3'b010;
        #1;
`ifdef DMEM_MISALIGN_TRAP_EN
        check_eq("ma_flag",  misalign, 1);
        check_eq("ma_err",   bus_err,  1);
        check_eq("ma_stall", stall,    0);
        tick();
        quiet();
        #1;
        check_eq("ma_req",    bus_req,  0);
        check_eq("ma_flag_0", misalign, 0);
        tick();
        #1;
        check_eq("ma_req_1", bus_req, 0);
`else
        check_eq("ma_stall", stall,   1);
        check_eq("ma_err",   bus_err, 0);
        tick();
        quiet(); bus_ack = 1'b1; bus_rdata = 32'h11223344;
        #1;
        check_eq("ma_req",  bus_req,  1);
        check_eq("ma_addr", bus_addr, 32'h100);
        tick();
        quiet();
        #1;
        check_eq("ma_rvalid", rdata_valid, 1);
        check_eq("ma_rdata",  rdata,       32'h11223344);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_bus_ctrl.md
DMEM_BUS_CTRL -- requirements
Module: dmem_bus_ctrl

Interface
REQ-001 Parameters SHALL be: TIMEOUT, 16, max cycles waiting for bus_ack before abort (2..255).
REQ-002 clk input 1 sole clock; all state SHALL update on rising edge.
REQ-003 reset input 1; reset SHALL be synchronous and active-high.
REQ-004 mem_read input 1 load request from datapath.
REQ-005 mem_write input 1 store request from datapath.
REQ-006 addr input 32 byte address (ALU result).
REQ-007 funct3 input 3 load/store width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 wdata input 32 store data, already lane-shifted by the byte-enable stage.
REQ-009 byte_en input 4 byte lane enables from the byte-enable stage.
REQ-010 stall output 1 freeze PC/pipeline while access is outstanding.
REQ-011 rdata output 32 raw word returned to byte-enable stage for lane extraction.
REQ-012 rdata_valid output 1 one-cycle pulse, rdata valid.
REQ-013 bus_req, bus_we outputs 1 each; bus_addr output 32; bus_wdata output 32; bus_be output 4.
REQ-014 bus_ack input 1; bus_rdata input 32 from data RAM.
REQ-015 bus_err output 1 one-cycle pulse on timeout (or misalignment, REQ-033).

Function
REQ-016 FSM states SHALL be IDLE, REQ, DONE.
REQ-017 IDLE: on mem_read|mem_write, the block SHALL capture addr, wdata, byte_en, funct3 and write flag, and go to REQ next cycle.
REQ-018 stall SHALL be combinational: high in IDLE when a request is present, high throughout REQ, low in DONE and idle IDLE.
REQ-019 REQ: bus_req SHALL be high; bus_addr SHALL be {captured addr[31:2],2'b00}; bus_we, bus_wdata, bus_be SHALL hold captured values and be stable until ack.
REQ-020 Read: bus_be SHALL be 4'b1111 regardless of byte_en.
REQ-021 On bus_ack=1 in REQ: bus_rdata SHALL be registered (reads), go to DONE.
REQ-022 DONE: rdata_valid=1 for exactly one cycle (reads only); stall=0; return to IDLE next cycle.
REQ-023 Minimum access latency: request cycle + 1 REQ cycle + DONE = 3 cycles; stall high 2 cycles with ack on first REQ cycle.
REQ-024 rdata SHALL hold last captured value until next read completes.
REQ-025 mem_read and mem_write both high SHALL be treated as a write.
REQ-026 New requests in DONE SHALL be ignored; datapath re-presents them in the following IDLE cycle.
REQ-027 bus_ack outside REQ SHALL be ignored.
REQ-028 Wait counter SHALL count REQ cycles; when TIMEOUT cycles elapse without ack, bus_req drops, bus_err pulses, rdata is set to 32'h0, FSM goes to DONE (rdata_valid still pulses for reads).
REQ-029 Write with byte_en=4'b0000 SHALL complete in IDLE without a bus cycle and without stall.

Reset
REQ-030 reset SHALL force IDLE; stall=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, rdata=0, rdata_valid=0, bus_err=0, wait counter=0.
REQ-031 reset during REQ SHALL drop bus_req on the next edge; the aborted access is not reported.

Configuration
REQ-032 Macro DMEM_MISALIGN_TRAP_EN SHALL gate misalignment checking.
REQ-033 Defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 SHALL issue no bus cycle, pulse bus_err and misalign (extra output, 1 bit) in the request cycle, no stall; undefined: access proceeds with word-aligned bus_addr, port misalign absent.

Structure
REQ-034 Shared package dmem_pkg SHALL hold the state enum and funct3 width constants.
REQ-035 Wait counter SHALL be sub-module dmem_timeout_cnt (clear, enable, expired).

Verification
REQ-036 Read addr=0x104, ack on 1st REQ cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x104, bus_be=1111, stall 2 cycles, rdata_valid with rdata=0xDEADBEEF.
REQ-037 SB addr=0x203, wdata=0xAB000000, byte_en=1000, ack after 3 cycles -> bus_we=1, bus_addr=0x200, bus_be=1000 stable, stall 4 cycles.
REQ-038 Read with no ack, TIMEOUT=16 -> bus_req high 16 cycles, bus_err pulse, rdata=0.
REQ-039 reset asserted on 2nd REQ cycle -> bus_req=0 next edge, no rdata_valid, FSM IDLE.
REQ-040 With DMEM_MISALIGN_TRAP_EN, LW addr=0x102 -> misalign=1, bus_err=1, bus_req never asserted.
REQ-041 mem_read=mem_write=1, byte_en=0011 -> write issued, no rdata_valid.
